ibuffer: RTL

- Instruction buffer between the fetch unit and decode.
- Accepts one fetch bundle per cycle: base PC, INSTR_PER_FETCH instruction words, per-slot valid mask, per-slot predicted next PC.
- Compacts the valid slots into a circular per-instruction queue and presents up to DEC_WIDTH oldest instructions per cycle to decode.
- Backend flush discards all buffered contents.

---
 rtl/ibuffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ibuffer.sv
// Instruction buffer between fetch and decode: compacts valid fetch slots into a
// circular per-instruction queue and presents up to DEC_WIDTH oldest entries per cycle.
package config_pkg;
  typedef struct packed {
    int unsigned PLEN;
    int unsigned ILEN;
    int unsigned INSTR_PER_FETCH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{PLEN: 32'd32, ILEN: 32'd32, INSTR_PER_FETCH: 32'd4};
endpackage

module ibuffer #(
  parameter config_pkg::cfg_t Cfg       = config_pkg::EmptyCfg,
  parameter int unsigned      DEPTH     = 16,
  parameter int unsigned      DEC_WIDTH = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ifu_ibuffer_rsp_valid_i,
  output logic                                       ibuffer_ifu_rsp_ready_o,
  input  logic [Cfg.PLEN-1:0]                        ifu_ibuffer_rsp_pc_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]    ifu_ibuffer_rsp_data_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]             ifu_ibuffer_rsp_slot_valid_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.PLEN-1:0]    ifu_ibuffer_rsp_pred_npc_i,
  output logic [DEC_WIDTH-1:0]                       ibuf2dec_valid_o,
  output logic [DEC_WIDTH*Cfg.ILEN-1:0]              ibuf2dec_instr_o,
  output logic [DEC_WIDTH*Cfg.PLEN-1:0]              ibuf2dec_pc_o,
  output logic [DEC_WIDTH*Cfg.PLEN-1:0]              ibuf2dec_pred_npc_o,
  input  logic                                       dec2ibuf_ready_i,
  input  logic                                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0]                 count_o
);

  localparam int unsigned W    = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN = Cfg.ILEN;
  localparam int unsigned PLEN = Cfg.PLEN;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH+1);

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [PLEN-1:0] pc_q    [DEPTH];
  logic [PLEN-1:0] npc_q   [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] slot_idx [W];
  logic [CW-1:0] enq_k;
  logic [CW-1:0] avail;
  logic [CW-1:0] deq_n;
  logic [CW:0]   free_slots;
  logic          enq_fire;
  logic          deq_fire;
  logic [AW-1:0] lane_idx;

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    enq_k = '0;
    for (int unsigned i = 0; i < W; i++) begin
      slot_idx[i] = tail_q + AW'(enq_k);
      if (ifu_ibuffer_rsp_slot_valid_i[i]) enq_k = enq_k + CW'(1);
    end
  end

  always_comb begin
    free_slots              = (CW+1)'(DEPTH) - {1'b0, count_q};
    ibuffer_ifu_rsp_ready_o = !rst && !flush_i && (free_slots >= (CW+1)'(W));
    enq_fire                = ifu_ibuffer_rsp_valid_i && ibuffer_ifu_rsp_ready_o;
    avail                   = (count_q < CW'(DEC_WIDTH)) ? count_q : CW'(DEC_WIDTH);
    deq_n                   = (rst || flush_i) ? '0 : avail;
    deq_fire                = dec2ibuf_ready_i && (deq_n != '0);
    count_o                 = count_q;
  end

  always_comb begin
    ibuf2dec_valid_o    = '0;
    ibuf2dec_instr_o    = '0;
    ibuf2dec_pc_o       = '0;
    ibuf2dec_pred_npc_o = '0;
    lane_idx            = '0;
    for (int unsigned j = 0; j < DEC_WIDTH; j++) begin
      lane_idx                              = head_q + AW'(j);
      ibuf2dec_valid_o[j]                   = CW'(j) < deq_n;
      ibuf2dec_instr_o[j*ILEN +: ILEN]      = instr_q[lane_idx];
      ibuf2dec_pc_o[j*PLEN +: PLEN]         = pc_q[lane_idx];
      ibuf2dec_pred_npc_o[j*PLEN +: PLEN]   = npc_q[lane_idx];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d  = tail_q + AW'(enq_k);
        count_d = count_d + enq_k;
      end
      if (deq_fire) begin
        head_d  = head_q + AW'(deq_n);
        count_d = count_d - deq_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (ifu_ibuffer_rsp_slot_valid_i[i]) begin
          instr_q[slot_idx[i]] <= ifu_ibuffer_rsp_data_i[i*ILEN +: ILEN];
          pc_q[slot_idx[i]]    <= ifu_ibuffer_rsp_pc_i + PLEN'(4*i);
          npc_q[slot_idx[i]]   <= ifu_ibuffer_rsp_pred_npc_i[i*PLEN +: PLEN];
        end
      end
    end
  end

endmodule
